// File: rtl/uart_defs_pkg.sv
// Shared UART definitions: FSM state encoding, frame geometry, line levels.
package uart_defs;

    localparam int unsigned UART_DATA_BITS = 8;
    localparam int unsigned BIT_IDX_W      = $clog2(UART_DATA_BITS);
    localparam logic        LINE_IDLE      = 1'b1;
    localparam logic        LINE_START     = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

endpackage

// File: rtl/tx_uart_fifo.sv
// Byte FIFO with show-ahead head output and registered full/empty flags.
// Callers must not push when full or pop when empty.
module fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_c,
    output logic                  full,
    output logic                  empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic [CW-1:0]         count_nxt;

    assign head_c = mem[rd_ptr];

    // Occupancy after this cycle's push/pop
    always_comb begin
        count_nxt = count + CW'(push) - CW'(pop);
    end

    // Storage array, no reset needed
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers, count and flags; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

endmodule

// File: rtl/tx_uart.sv
// Buffered UART transmitter, 8N1 LSB first, div clocks per bit.
// Build option TX_UART_PARITY_EN adds an even-parity bit (8E1).
module tx_uart
    import uart_defs::*;
#(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned DIV_WIDTH  = 16
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      data_wr,
    input  logic [UART_DATA_BITS-1:0] data_in,
    input  logic [DIV_WIDTH-1:0]      div,
    output logic                      tx_out,
    output logic                      fifo_full,
    output logic                      busy,
    output logic                      overflow
);

    tx_state_e                 state_q, state_nxt;
    logic [DIV_WIDTH-1:0]      timer_q, timer_nxt;
    logic [DIV_WIDTH-1:0]      div_q, div_nxt;
    logic [BIT_IDX_W-1:0]      bit_idx_q, bit_idx_nxt;
    logic [UART_DATA_BITS-1:0] shreg_q, shreg_nxt;
    logic                      tx_nxt;
    logic                      busy_nxt;
    logic                      push_c;
    logic                      pop_c;
    logic                      fifo_empty;
    logic [UART_DATA_BITS-1:0] head_c;
    logic                      timer_done_c;

    // Full is the registered flag, so a write in a popping cycle is still dropped
    assign push_c       = data_wr & ~fifo_full;
    assign timer_done_c = (timer_q == DIV_WIDTH'(1));

    fifo #(
        .DATA_WIDTH (UART_DATA_BITS),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push_c),
        .wdata  (data_in),
        .pop    (pop_c),
        .head_c (head_c),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // Frame sequencing, bit timer and next line level
    always_comb begin
        state_nxt   = state_q;
        timer_nxt   = timer_q;
        div_nxt     = div_q;
        bit_idx_nxt = bit_idx_q;
        shreg_nxt   = shreg_q;
        pop_c       = 1'b0;
        tx_nxt      = LINE_IDLE;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop_c     = 1'b1;
                    shreg_nxt = head_c;
                    div_nxt   = (div == '0) ? DIV_WIDTH'(1) : div;
                    timer_nxt = (div == '0) ? DIV_WIDTH'(1) : div;
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (timer_done_c) begin
                    timer_nxt   = div_q;
                    bit_idx_nxt = '0;
                    state_nxt   = ST_DATA;
                end else begin
                    timer_nxt = timer_q - DIV_WIDTH'(1);
                end
            end
            ST_DATA: begin
                if (timer_done_c) begin
                    timer_nxt = div_q;
                    if (bit_idx_q == BIT_IDX_W'(UART_DATA_BITS - 1)) begin
`ifdef TX_UART_PARITY_EN
                        state_nxt = ST_PARITY;
`else
                        state_nxt = ST_STOP;
`endif
                    end else begin
                        bit_idx_nxt = bit_idx_q + BIT_IDX_W'(1);
                    end
                end else begin
                    timer_nxt = timer_q - DIV_WIDTH'(1);
                end
            end
`ifdef TX_UART_PARITY_EN
            ST_PARITY: begin
                if (timer_done_c) begin
                    timer_nxt = div_q;
                    state_nxt = ST_STOP;
                end else begin
                    timer_nxt = timer_q - DIV_WIDTH'(1);
                end
            end
`endif
            ST_STOP: begin
                if (timer_done_c) begin
                    state_nxt = ST_IDLE;
                end else begin
                    timer_nxt = timer_q - DIV_WIDTH'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        case (state_nxt)
            ST_START: tx_nxt = LINE_START;
            ST_DATA:  tx_nxt = shreg_nxt[bit_idx_nxt];
`ifdef TX_UART_PARITY_EN
            ST_PARITY: tx_nxt = ^shreg_nxt;
`endif
            default:  tx_nxt = LINE_IDLE;
        endcase

        // FIFO only drains from IDLE (which then leaves IDLE), so next-cycle
        // non-emptiness reduces to current non-empty or a push now
        busy_nxt = (state_nxt != ST_IDLE) | ~fifo_empty | push_c;
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            div_q     <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            tx_out    <= LINE_IDLE;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            timer_q   <= timer_nxt;
            div_q     <= div_nxt;
            bit_idx_q <= bit_idx_nxt;
            shreg_q   <= shreg_nxt;
            tx_out    <= tx_nxt;
            busy      <= busy_nxt;
        end
    end

    // Sticky flag for writes dropped on a full FIFO
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overflow <= 1'b0;
        end else if (data_wr && fifo_full) begin
            overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_tx_uart.sv
// Testbench for tx_uart: table of single-byte frames plus burst, overflow,
// divider-change, reset and (with TX_UART_PARITY_EN) parity sequences.
// A line-level receiver decodes every frame against a scoreboard queue.
module tb_tx_uart;

`ifdef TX_UART_PARITY_EN
    localparam int unsigned NBITS = 11;
`else
    localparam int unsigned NBITS = 10;
`endif

    logic        clk;
    logic        resetn;
    logic        data_wr;
    logic [7:0]  data_in;
    logic [15:0] div;
    logic        tx_out;
    logic        fifo_full;
    logic        busy;
    logic        overflow;

    tx_uart #(.FIFO_DEPTH(16), .DIV_WIDTH(16)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .data_wr   (data_wr),
        .data_in   (data_in),
        .div       (div),
        .tx_out    (tx_out),
        .fifo_full (fifo_full),
        .busy      (busy),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0]  data;
        int unsigned len;
    } exp_t;

    typedef struct {
        logic [15:0] div;
        logic [7:0]  data;
        int unsigned deff;
        int unsigned lat;
        int unsigned busy_end;
    } vec_t;

    exp_t        exp_q[$];
    int unsigned start_q[$];
    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned rx_cnt = 0;
    int unsigned wr_cyc = 0;
    bit          mon_en = 1'b0;
    bit          mon_busy = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
    endtask

    function automatic logic exp_level(input logic [7:0] d, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
`ifdef TX_UART_PARITY_EN
        if (b == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    // Line receiver: checks every cycle of every frame against the scoreboard entry
    exp_t       mon_e;
    logic [7:0] mon_got;
    bit         mon_bad;
    bit         mon_abort;
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && resetn === 1'b1 && tx_out === 1'b0) begin
                start_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_start: start bit at cycle %0d, required none", cyc);
                end else begin
                    mon_busy  = 1'b1;
                    mon_e     = exp_q.pop_front();
                    mon_got   = '0;
                    mon_bad   = 1'b0;
                    mon_abort = 1'b0;
                    for (int b = 0; b < int'(NBITS) && !mon_abort; b++) begin
                        for (int c = 0; c < int'(mon_e.len); c++) begin
                            if (!(b == 0 && c == 0)) @(negedge clk);
                            if (resetn !== 1'b1) begin
                                mon_abort = 1'b1;
                                break;
                            end
                            if (c == 0 && b >= 1 && b <= 8) mon_got[b-1] = tx_out;
                            if (tx_out !== exp_level(mon_e.data, b)) mon_bad = 1'b1;
                        end
                    end
                    if (!mon_abort) begin
                        rx_cnt++;
                        chk("frame", {23'd0, mon_bad, mon_got}, {24'd0, mon_e.data});
                    end
                    mon_busy = 1'b0;
                end
            end
        end
    end

    task automatic wr(input logic [7:0] b, input int unsigned deff, input bit accept);
        @(posedge clk); #1;
        data_wr = 1'b1;
        data_in = b;
        wr_cyc  = cyc;
        if (accept) exp_q.push_back('{b, deff});
        @(posedge clk); #1;
        data_wr = 1'b0;
    endtask

    task automatic wait_idle(input int unsigned bound);
        int unsigned t = 0;
        while ((busy !== 1'b0 || mon_busy || exp_q.size() != 0) && t < bound) begin
            @(negedge clk);
            t++;
        end
        if (t >= bound) timeout("idle");
        repeat (2) @(posedge clk);
        #1;
    endtask

    vec_t        tbl [5];
    logic [7:0]  bb [3];
    int unsigned t;
    int unsigned w;
    int unsigned n0;

    initial begin
        resetn  = 1'b0;
        data_wr = 1'b0;
        data_in = '0;
        div     = 16'd4;

        tbl[0] = '{16'd4, 8'h55, 4, 2, 2 + NBITS*4};
        tbl[1] = '{16'd0, 8'hA3, 1, 2, 2 + NBITS*1};
        tbl[2] = '{16'd1, 8'h3C, 1, 2, 2 + NBITS*1};
        tbl[3] = '{16'd3, 8'h81, 3, 2, 2 + NBITS*3};
        tbl[4] = '{16'd7, 8'hC6, 7, 2, 2 + NBITS*7};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_tx_out", tx_out, 1);
        chk("rst_busy", busy, 0);
        chk("rst_fifo_full", fifo_full, 0);
        chk("rst_overflow", overflow, 0);
        @(posedge clk); #1;
        resetn = 1'b1;
        mon_en = 1'b1;

        // Single-byte frames: start latency and busy duration
        for (int i = 0; i < 5; i++) begin
            wait_idle(5000);
            start_q.delete();
            div = tbl[i].div;
            wr(tbl[i].data, tbl[i].deff, 1'b1);
            w = wr_cyc;
            t = 0;
            while (start_q.size() == 0 && t < 100) begin
                @(posedge clk);
                t++;
            end
            if (start_q.size() == 0) timeout("start_seen");
            else chk("start_lat", start_q[0] - w, tbl[i].lat);
            t = 0;
            while (busy === 1'b1 && t < 3000) begin
                @(negedge clk);
                t++;
            end
            chk("busy_end", cyc - w, tbl[i].busy_end);
        end

        // Burst of three bytes on consecutive cycles
        wait_idle(5000);
        start_q.delete();
        div = 16'd2;
        bb[0] = 8'h00; bb[1] = 8'hFF; bb[2] = 8'hA5;
        @(posedge clk); #1;
        data_wr = 1'b1;
        for (int k = 0; k < 3; k++) begin
            data_in = bb[k];
            exp_q.push_back('{bb[k], 2});
            @(posedge clk); #1;
        end
        data_wr = 1'b0;
        wait_idle(5000);
        chk("burst_frames", start_q.size(), 3);
        if (start_q.size() == 3) begin
            chk("burst_gap0", start_q[1] - start_q[0], NBITS*2 + 1);
            chk("burst_gap1", start_q[2] - start_q[1], NBITS*2 + 1);
        end

        // Overflow: 18 back-to-back writes, the last one dropped
        div = 16'd100;
        n0 = rx_cnt;
        for (int k = 0; k < 18; k++) begin
            @(posedge clk); #1;
            data_wr = 1'b1;
            data_in = 8'h10 + 8'(k);
            if (k < 17) exp_q.push_back('{8'h10 + 8'(k), 100});
            @(negedge clk);
            if (k == 16) chk("full_before", fifo_full, 0);
            if (k == 17) begin
                chk("full_at_18", fifo_full, 1);
                chk("ovf_not_yet", overflow, 0);
            end
        end
        @(posedge clk); #1;
        data_wr = 1'b0;
        @(negedge clk);
        chk("ovf_set", overflow, 1);
        wait_idle(25000);
        chk("ovf_sent", rx_cnt - n0, 17);
        chk("ovf_sticky", overflow, 1);

        // Divider change mid-frame takes effect on the next frame only
        start_q.delete();
        div = 16'd3;
        wr(8'h6D, 3, 1'b1);
        repeat (11) @(posedge clk);
        #1;
        div = 16'd5;
        wr(8'hB2, 5, 1'b1);
        wait_idle(5000);
        chk("div_frames", start_q.size(), 2);
        if (start_q.size() == 2) chk("div_gap", start_q[1] - start_q[0], NBITS*3 + 1);

        // Reset during data bit 3; queued byte must be lost
        start_q.delete();
        div = 16'd4;
        wr(8'h00, 4, 1'b1);
        w = wr_cyc;
        wr(8'h42, 4, 1'b1);
        t = 0;
        while (cyc != w + 19 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("bit3_low", tx_out, 0);
        #1;
        resetn = 1'b0;
        #1;
        chk("mid_rst_tx_out", tx_out, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_full", fifo_full, 0);
        chk("mid_rst_overflow", overflow, 0);
        repeat (3) @(posedge clk);
        #1;
        exp_q.delete();
        resetn = 1'b1;
        n0 = start_q.size();
        repeat (300) @(posedge clk);
        @(negedge clk);
        chk("post_rst_starts", start_q.size() - n0, 0);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_tx_out", tx_out, 1);

`ifdef TX_UART_PARITY_EN
        // Even parity: 0x07 -> 1, 0x03 -> 0; 8E1 frame period
        wait_idle(5000);
        start_q.delete();
        div = 16'd2;
        bb[0] = 8'h07; bb[1] = 8'h03;
        @(posedge clk); #1;
        data_wr = 1'b1;
        for (int k = 0; k < 2; k++) begin
            data_in = bb[k];
            exp_q.push_back('{bb[k], 2});
            @(posedge clk); #1;
        end
        data_wr = 1'b0;
        wait_idle(5000);
        chk("par_frames", start_q.size(), 2);
        if (start_q.size() == 2) chk("par_gap", start_q[1] - start_q[0], 23);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
